// File: rtl/gpio_led_ctrl_if.sv
// GPIO merge / LED channel bundle between the M3 GPIO ports, the LED controller and the board pins.
// master drives M3 GPIO and channel configuration; slave returns the merged GPIO buffer and LED drive.
interface gpio_led_ctrl_if #(
   parameter int CHANNELS  = 4,
   parameter int CNT_WIDTH = 27
);
   logic [CHANNELS-1:0]           gpio_out;
   logic [CHANNELS-1:0]           gpio_en;
   logic [CHANNELS-1:0]           gpio_state;
   logic [2*CHANNELS-1:0]         mode;
   logic [CNT_WIDTH*CHANNELS-1:0] period;
   logic [CHANNELS-1:0]           period_load;
   logic [CHANNELS-1:0]           led;
   logic [CHANNELS-1:0]           tick;

   modport master (
      output gpio_out, gpio_en, mode, period, period_load,
      input  gpio_state, led, tick
   );

   modport slave (
      input  gpio_out, gpio_en, mode, period, period_load,
      output gpio_state, led, tick
   );
endinterface

// File: rtl/gpio_led_ctrl.sv
// Merges M3 GPIO outputs into the gpioin buffer and drives per-channel LEDs (follow/blink/one-shot/on).
// GPIO merge has 1 cycle latency, LED follow 2 cycles; no backpressure, every input is sampled each cycle.
module gpio_led_ctrl #(
   parameter int CHANNELS       = 4,
   parameter int CNT_WIDTH      = 27,
   parameter int DEFAULT_PERIOD = 40500000
) (
   input  logic           clk,
   input  logic           reset,
   gpio_led_ctrl_if.slave bus
);
   localparam logic [CNT_WIDTH-1:0] PERIOD_RST = CNT_WIDTH'(DEFAULT_PERIOD);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
   localparam logic [1:0] M_FOLLOW = 2'b00;
   localparam logic [1:0] M_BLINK  = 2'b01;
   localparam logic [1:0] M_SHOT   = 2'b10;

   logic [CHANNELS-1:0]  gpio_state_q, gpio_state_d, gpio_prev;
   logic [CHANNELS-1:0]  blink_q, blink_d, pulse_q, pulse_d;
   logic [CHANNELS-1:0]  led_q, led_d, tick_q, tick_d;
   logic [CHANNELS-1:0]  trig, wrap, mode_chg;
   logic [1:0]           mode_q [CHANNELS];
   logic [1:0]           mode_in [CHANNELS];
   logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
   logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];
   logic [CNT_WIDTH-1:0] period_q [CHANNELS];
   logic [CNT_WIDTH-1:0] period_d [CHANNELS];

   assign gpio_state_d = (gpio_state_q & ~bus.gpio_en) | (bus.gpio_out & bus.gpio_en);

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         mode_in[i]  = bus.mode[2*i +: 2];
         trig[i]     = gpio_state_q[i] & ~gpio_prev[i];
         wrap[i]     = (cnt_q[i] == period_q[i]);
         mode_chg[i] = (mode_q[i] != mode_in[i]);
      end
   end

   always_comb begin
      blink_d = blink_q;
      pulse_d = pulse_q;
      tick_d  = '0;
      led_d   = led_q;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i]    = cnt_q[i];
         period_d[i] = bus.period_load[i] ? bus.period[CNT_WIDTH*i +: CNT_WIDTH] : period_q[i];

         // LED follows the newly selected mode immediately; flags still hold their pre-change value.
         case (mode_in[i])
            M_FOLLOW: led_d[i] = gpio_state_q[i];
            M_BLINK:  led_d[i] = blink_q[i];
            M_SHOT:   led_d[i] = pulse_q[i];
            default:  led_d[i] = 1'b1;
         endcase

         if (mode_chg[i]) begin
            cnt_d[i]   = '0;
            blink_d[i] = 1'b0;
            pulse_d[i] = 1'b0;
         end else if (bus.period_load[i]) begin
            cnt_d[i] = '0;
         end else begin
            case (mode_in[i])
               M_BLINK: begin
                  if (wrap[i]) begin
                     blink_d[i] = ~blink_q[i];
                     cnt_d[i]   = '0;
                     tick_d[i]  = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_ONE;
                  end
               end
               M_SHOT: begin
                  // A retrigger beats a same-cycle expiry, so the pulse stretches without a tick.
                  if (trig[i]) begin
                     pulse_d[i] = 1'b1;
                     cnt_d[i]   = '0;
                  end else if (pulse_q[i]) begin
                     if (wrap[i]) begin
                        pulse_d[i] = 1'b0;
                        cnt_d[i]   = '0;
                        tick_d[i]  = 1'b1;
                     end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                     end
                  end else begin
                     cnt_d[i] = '0;
                  end
               end
               default: cnt_d[i] = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gpio_state_q <= '0;
         gpio_prev    <= '0;
         blink_q      <= '0;
         pulse_q      <= '0;
         led_q        <= '0;
         tick_q       <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            mode_q[i]   <= M_FOLLOW;
            cnt_q[i]    <= '0;
            period_q[i] <= PERIOD_RST;
         end
      end else begin
         gpio_state_q <= gpio_state_d;
         gpio_prev    <= gpio_state_q;
         blink_q      <= blink_d;
         pulse_q      <= pulse_d;
         led_q        <= led_d;
         tick_q       <= tick_d;
         for (int i = 0; i < CHANNELS; i++) begin
            mode_q[i]   <= mode_in[i];
            cnt_q[i]    <= cnt_d[i];
            period_q[i] <= period_d[i];
         end
      end
   end

   assign bus.gpio_state = gpio_state_q;
   assign bus.led        = led_q;
   assign bus.tick       = tick_q;
endmodule
